// File: rtl/dmem_mmio_pkg.sv
// Shared address map, STATUS layout and decode helper for the dmem_mmio
// data-bus responder.
package dmem_mmio_pkg;

  localparam logic [31:0] RAM_LIMIT    = 32'h0000_0100;
  localparam logic [31:0] ADDR_TXDATA  = 32'h0000_0100;
  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0104;
  localparam logic [31:0] ADDR_GPIO    = 32'h0000_0108;
  localparam logic [31:0] ADDR_CYCLE   = 32'h0000_010C;
  localparam logic [31:0] ADDR_DROPPED = 32'h0000_0110;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  typedef enum logic [2:0] {
    SEL_RAM     = 3'd0,
    SEL_TXDATA  = 3'd1,
    SEL_STATUS  = 3'd2,
    SEL_GPIO    = 3'd3,
    SEL_CYCLE   = 3'd4,
    SEL_DROPPED = 3'd5,
    SEL_NONE    = 3'd6
  } sel_e;

  // Decode a word address (byte address bits [31:2]) into a target select.
  function automatic sel_e decode_addr(input logic [29:0] word_adr);
    logic [31:0] adr;
    adr = {word_adr, 2'b00};
    if (adr < RAM_LIMIT) begin
      return SEL_RAM;
    end else begin
      case (adr)
        ADDR_TXDATA:  return SEL_TXDATA;
        ADDR_STATUS:  return SEL_STATUS;
        ADDR_GPIO:    return SEL_GPIO;
        ADDR_CYCLE:   return SEL_CYCLE;
        ADDR_DROPPED: return SEL_DROPPED;
        default:      return SEL_NONE;
      endcase
    end
  endfunction

endpackage

// File: rtl/dmem_mmio_sync_fifo.sv
// Synchronous FIFO with registered pointers/count; head reads 0 while empty
// so the stream data is defined after reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == {(AW+1){1'b0}});
  assign count_o = count_q;
  assign head_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Next-state: fullness/emptiness are taken from the pre-edge count.
  always_comb begin
    push_ok_s = push_i && !full_o;
    pop_ok_s  = pop_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-port responder for the single-cycle core: word RAM plus an MMIO window
// with a transmit FIFO, GPIO, cycle counter and dropped-push counter.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [7:0]  gpio_out
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [7:0]        gpio_q, gpio_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [7:0]        dropped_q, dropped_d;

  sel_e              sel_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic              ram_we_s;
  logic              push_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [31:0]       status_s;
  logic              unused_adr_s;

  assign sel_s        = decode_addr(DataAdr[31:2]);
  assign ram_idx_s    = DataAdr[2 +: RAM_AW];
  assign unused_adr_s = ^DataAdr[1:0];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (tx_ready),
    .wdata_i (WriteData[7:0]),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s),
    .head_o  (tx_data)
  );

  assign tx_valid = !fifo_empty_s;
  assign gpio_out = gpio_q;

  // Store decode and next-state for the MMIO registers.
  always_comb begin
    push_s    = MemWrite && (sel_s == SEL_TXDATA);
    ram_we_s  = MemWrite && (sel_s == SEL_RAM);
    gpio_d    = gpio_q;
    cycle_d   = cycle_q + 32'd1;
    dropped_d = dropped_q;
    if (MemWrite) begin
      case (sel_s)
        SEL_GPIO:    gpio_d    = WriteData[7:0];
        SEL_CYCLE:   cycle_d   = WriteData;
        SEL_DROPPED: dropped_d = 8'd0;
        SEL_TXDATA: begin
          // A full FIFO drops the push even if a pop frees a slot this edge.
          if (fifo_full_s && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
          end else begin
            dropped_d = dropped_q;
          end
        end
        default:     gpio_d    = gpio_q;
      endcase
    end else begin
      dropped_d = dropped_q;
    end
  end

  // MMIO register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q    <= 8'd0;
      cycle_q   <= 32'd0;
      dropped_q <= 8'd0;
    end else begin
      gpio_q    <= gpio_d;
      cycle_q   <= cycle_d;
      dropped_q <= dropped_d;
    end
  end

  // Word RAM, deliberately without reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= WriteData;
    end
  end

  // Combinational load path so the core completes loads in one cycle.
  always_comb begin
    status_s                                  = 32'd0;
    status_s[STATUS_FULL_BIT]                 = fifo_full_s;
    status_s[STATUS_EMPTY_BIT]                = fifo_empty_s;
    status_s[STATUS_COUNT_LSB +: CNT_W]       = fifo_count_s;
    case (sel_s)
      SEL_RAM:     ReadData = ram_q[ram_idx_s];
      SEL_STATUS:  ReadData = status_s;
      SEL_GPIO:    ReadData = {24'd0, gpio_q};
      SEL_CYCLE:   ReadData = cycle_q;
      SEL_DROPPED: ReadData = {24'd0, dropped_q};
      default:     ReadData = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized scoreboard bench for dmem_mmio against a queue-based reference model.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [7:0]  gpio_out;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .gpio_out  (gpio_out)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        txv;
    logic [7:0]  gpio;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  txq[$];

  logic [31:0] m_ram[64];
  bit          m_ram_ok[64];
  logic [7:0]  m_fifo[$];
  logic [7:0]  m_gpio;
  logic [7:0]  m_drop;
  logic [31:0] m_cycle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h100) return m_ram[w[7:2]];
    case (w)
      32'h104: return {16'd0, 8'(m_fifo.size()), 6'd0,
                       1'(m_fifo.size() == 0), 1'(m_fifo.size() == 8)};
      32'h108: return {24'd0, m_gpio};
      32'h10C: return m_cycle;
      32'h110: return {24'd0, m_drop};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_fifo.delete();
    txq.delete();
    m_gpio  = 8'd0;
    m_drop  = 8'd0;
    m_cycle = 32'd0;
  endtask

  task automatic m_edge(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic [31:0] w;
    bit          full;
    w    = {a[31:2], 2'b00};
    full = (m_fifo.size() == 8);
    if (m_fifo.size() > 0 && rdy) begin
      txq.push_back(m_fifo[0]);
      void'(m_fifo.pop_front());
    end
    m_cycle = m_cycle + 32'd1;
    if (we) begin
      if (w < 32'h100) begin
        m_ram[w[7:2]]    = wd;
        m_ram_ok[w[7:2]] = 1'b1;
      end else begin
        case (w)
          32'h100: if (full) begin
                     if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
                   end else m_fifo.push_back(wd[7:0]);
          32'h108: m_gpio  = wd[7:0];
          32'h10C: m_cycle = wd;
          32'h110: m_drop  = 8'd0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    exp_t        e;
    logic [31:0] w;
    @(posedge clk);
    #1;
    MemWrite  = we;
    DataAdr   = a;
    WriteData = wd;
    tx_ready  = rdy;
    w         = {a[31:2], 2'b00};
    e.chk_rd  = (w >= 32'h100) || m_ram_ok[w[7:2]];
    e.rd      = m_read(a);
    e.txv     = (m_fifo.size() > 0);
    e.gpio    = m_gpio;
    expq.push_back(e);
    m_edge(we, a, wd, rdy);
  endtask

  // Monitor: one expectation per cycle, plus the tx stream on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.chk_rd) check("read_data", ReadData, e.rd);
        check("tx_valid", 32'(tx_valid), 32'(e.txv));
        check("gpio_out", 32'(gpio_out), 32'(e.gpio));
        if (tx_valid && tx_ready) begin
          if (txq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected: got byte %02h expected none", tx_data);
          end else begin
            check("tx_data", 32'(tx_data), 32'(txq.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] others[4];
    logic [31:0] a;
    int          kind;
    others[0] = 32'h0000_0114;
    others[1] = 32'h0000_01FC;
    others[2] = 32'h8000_0004;
    others[3] = 32'hFFFF_FF00;

    reset = 1'b0; MemWrite = 1'b0; DataAdr = 32'h104; WriteData = 32'd0; tx_ready = 1'b0;
    #2;
    check("rst_status", ReadData, 32'h0000_0002);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_gpio", 32'(gpio_out), 32'd0);
    m_reset();
    @(negedge clk); #1 reset = 1'b1;
    m_edge(1'b0, 32'h104, 32'd0, 1'b0);

    step(1'b0, 32'h104, 32'd0, 1'b0);
    step(1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 32'h04, 32'd0, 1'b0);
    #1 check("ram_load", ReadData, 32'hDEAD_BEEF);

    for (int i = 0; i < 64; i++) step(1'b1, 32'(i) * 32'd4, $urandom, 1'b0);

    for (int b = 8'h41; b <= 8'h4A; b++) step(1'b1, 32'h100, 32'(b), 1'b0);
    step(1'b0, 32'h104, 32'd0, 1'b0);
    #1 check("status_full", ReadData, 32'h0000_0801);
    step(1'b0, 32'h110, 32'd0, 1'b0);
    #1 check("dropped_2", ReadData, 32'd2);
    step(1'b1, 32'h100, 32'h55, 1'b1);
    step(1'b0, 32'h104, 32'd0, 1'b0);
    #1 check("status_7", ReadData, 32'h0000_0700);
    step(1'b0, 32'h110, 32'd0, 1'b0);
    #1 check("dropped_3", ReadData, 32'd3);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h104, 32'd0, 1'b1);

    step(1'b1, 32'h10C, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h10C, 32'd0, 1'b0);
    #1 check("cycle_wrap", ReadData, 32'd0);

    step(1'b1, 32'h108, 32'h0000_01A5, 1'b0);
    step(1'b0, 32'h108, 32'd0, 1'b0);
    #1 check("gpio_pin", 32'(gpio_out), 32'h0000_00A5);
    check("gpio_load", ReadData, 32'h0000_00A5);
    step(1'b1, 32'h110, 32'd0, 1'b0);
    step(1'b0, 32'h110, 32'd0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 11);
      case (kind)
        0, 1, 2, 3: a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        4, 5, 6:    a = 32'h100 | 32'($urandom_range(0, 3));
        7:          a = 32'h104;
        8:          a = 32'h108 | 32'($urandom_range(0, 3));
        9:          a = 32'h10C;
        10:         a = 32'h110;
        default:    a = others[$urandom_range(0, 3)];
      endcase
      step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    step(1'b1, 32'h108, 32'h0000_003C, 1'b0);
    for (int b = 0; b < 4; b++) step(1'b1, 32'h100, 32'($urandom_range(0, 255)), 1'b0);
    step(1'b0, 32'h104, 32'd0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0; MemWrite = 1'b0; tx_ready = 1'b0; DataAdr = 32'h104;
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_gpio", 32'(gpio_out), 32'd0);
    m_reset();
    @(negedge clk); #1 reset = 1'b1;
    #1 check("post_rst_status", ReadData, 32'h0000_0002);
    DataAdr = 32'h10C;
    #1 check("post_rst_cycle0", ReadData, 32'd0);
    m_edge(1'b0, 32'h10C, 32'd0, 1'b0);
    step(1'b0, 32'h10C, 32'd0, 1'b0);
    #1 check("post_rst_cycle1", ReadData, 32'd1);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 3);
      a = (kind == 0) ? 32'h104 : 32'h100;
      step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 32'h104, 32'd0, 1'b1);
    @(negedge clk); #1;
    check("txq_left", 32'(txq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-bus responder for the single-cycle RISC-V core: it sits on the far end of the core's data port (write enable, address, write data, read data) and replaces the plain data memory. It serves a word RAM plus a small memory-mapped peripheral window. The window holds a byte transmit FIFO drained over a valid/ready stream, a GPIO output register, a free-running cycle counter and a dropped-write counter. Reads are combinational so the core can complete loads in its single cycle.

## Interface
- RAM_WORDS, 64, number of 32-bit RAM words (power of two, ≤ 64)
- FIFO_DEPTH, 8, transmit FIFO entries (power of two, ≥ 2)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- MemWrite  input  1  core store strobe for the current cycle
- DataAdr  input  32  byte address; word-aligned, DataAdr[1:0] ignored
- WriteData  input  32  store data
- ReadData  output  32  load data, combinational from DataAdr and current state
- tx_valid  output  1  FIFO head is valid
- tx_data  output  8  FIFO head byte
- tx_ready  input  1  sink accepts the head this cycle
- gpio_out  output  8  GPIO register

## Operation
- Address decode on DataAdr[31:2]:
  - RAM: 0x000–0x0FF, word index DataAdr[7:2] mod RAM_WORDS
  - 0x100 TXDATA: write pushes WriteData[7:0]; reads 0
  - 0x104 STATUS: bit0 full, bit1 empty, bits[15:8] occupancy count, others 0; writes ignored
  - 0x108 GPIO: read/write, bits[7:0], upper bits read 0
  - 0x10C CYCLE: reads the counter; a write loads WriteData
  - 0x110 DROPPED: reads the 8-bit saturating count of pushes lost to a full FIFO, upper bits 0; any write clears it
  - all other addresses: read 0, write ignored
- RAM is not reset. A store updates it on the edge. A load in the same cycle as a store to the same word returns the old value.
- CYCLE increments by 1 every cycle and wraps at 2^32. A write in the same cycle overrides the increment, so the next value equals WriteData.
- Push rule: fullness is evaluated before the edge.
  - A push while full is dropped and DROPPED increments, saturating at 255. This holds even if a pop happens in the same cycle.
  - A push while empty is accepted and no pop occurs that cycle.
- Pop happens when tx_valid && tx_ready. tx_valid = !empty and tx_data = head entry, both driven from registered state.
- A simultaneous push and pop with the FIFO neither full nor empty leaves the count unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth. Count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (asynchronous, while reset=0):
  - FIFO empty, tx_valid=0, tx_data=0
  - gpio_out=0, CYCLE=0, DROPPED=0
  - ReadData reflects this state combinationally
- Reset released mid-operation: FIFO contents are discarded. CYCLE reads 0 on the first cycle after release and 1 on the second.
- Store latency: one edge. A register written at edge N is visible to a load in cycle N+1.
- Push to an empty FIFO at edge N: tx_valid=1 in cycle N+1.
- The ready/valid transfer completes on the edge where both are high. tx_data is held stable while tx_valid=1 and tx_ready=0.
- No combinational path from tx_ready to tx_valid or tx_data.

## Structure
- Package dmem_mmio_pkg holds:
  - address constants: ADDR_TXDATA, ADDR_STATUS, ADDR_GPIO, ADDR_CYCLE, ADDR_DROPPED, RAM_LIMIT
  - STATUS bit positions
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push, pop, full, empty, count, head. Same clk/reset convention.
- Decode, RAM array, counters and the read mux live in dmem_mmio.

## Test plan
- RAM: store 0xDEADBEEF to 0x04, then load 0x04 → 0xDEADBEEF. Load 0x104 right after reset → 0x00000002 (empty).
- FIFO fill with tx_ready=0: write 0x41..0x4A (10 bytes) to 0x100.
  - STATUS then reads 0x00000801 (count 8, full) and DROPPED reads 2.
  - Raise tx_ready: bytes 0x41..0x48 appear in order, one per cycle, then tx_valid=0.
- Simultaneous push and pop while full: only the pop takes effect; count goes 8→7 and DROPPED increments.
- CYCLE: write 0xFFFFFFFE to 0x10C, then read 2 cycles later → 0x00000000 (wrap).
- GPIO: write 0x1A5 to 0x108 → gpio_out=0xA5, and a load reads 0x000000A5.
- Reset mid-stream: assert reset while tx_valid=1 → tx_valid=0 immediately (asynchronous); after release STATUS reads empty and gpio_out=0.
